// File: rtl/in_pin_conditioner.sv
// Pad input front end: synchroniser, per-pin debounce and edge detect feeding the pin mux. Latency SyncStages+DebounceCycles
// edges (debounced) or SyncStages+1 (bypass); no backpressure. Define IN_PIN_COND_GLITCH_CNT_EN for per-pin glitch counters.
module in_pin_conditioner #(
  parameter int unsigned        NumPins        = 5,
  parameter int unsigned        SyncStages     = 2,
  parameter int unsigned        DebounceCycles = 16,
  parameter logic [NumPins-1:0] ResetVal       = 5'b00111
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumPins-1:0]   pins_i,
  input  logic [NumPins-1:0]   debounce_en_i,
  output logic [NumPins-1:0]   pins_o,
  output logic [NumPins-1:0]   rise_o,
  output logic [NumPins-1:0]   fall_o,
  input  logic                 glitch_clr_i,
  output logic [NumPins*8-1:0] glitch_cnt_o
);

  localparam int unsigned     CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0][NumPins-1:0] sync_q, sync_d;
  logic [NumPins-1:0]                 sync_lvl;

  logic [NumPins-1:0]           stable_q, stable_d;
  logic [NumPins-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NumPins-1:0]           rise_q, fall_q;
  logic [NumPins-1:0]           glitch_evt;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pins_i;
    for (int i = 1; i < SyncStages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_lvl = sync_q[SyncStages-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SyncStages{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  always_comb begin
    stable_d   = stable_q;
    cnt_d      = '0;
    glitch_evt = '0;
    for (int n = 0; n < NumPins; n++) begin
      if (!debounce_en_i[n]) begin
        stable_d[n] = sync_lvl[n];
      end else if (sync_lvl[n] == stable_q[n]) begin
        // Level returned before the count completed: that excursion was a glitch.
        glitch_evt[n] = (cnt_q[n] != '0);
      end else if (cnt_q[n] == CntLast) begin
        stable_d[n] = sync_lvl[n];
      end else begin
        cnt_d[n] = cnt_q[n] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= ResetVal;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= stable_d & ~stable_q;
      fall_q   <= ~stable_d & stable_q;
    end
  end

  assign pins_o = stable_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef IN_PIN_COND_GLITCH_CNT_EN
  logic [NumPins-1:0][7:0] glitch_q, glitch_d;

  always_comb begin
    glitch_d = glitch_q;
    for (int n = 0; n < NumPins; n++) begin
      if (glitch_clr_i) begin
        glitch_d[n] = '0;
      end else if (glitch_evt[n] && (glitch_q[n] != 8'hFF)) begin
        glitch_d[n] = glitch_q[n] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt_o = glitch_q;
`else
  logic unused_glitch;
  assign unused_glitch = ^{glitch_clr_i, glitch_evt};
  assign glitch_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_in_pin_conditioner.sv
// Bench for in_pin_conditioner: directed scenarios plus a random soak against a run-length reference model.
module tb_in_pin_conditioner;

  localparam int            NP   = 5;
  localparam int            SYNC = 2;
  localparam int            DB   = 16;
  localparam logic [NP-1:0] RST  = 5'b00111;
`ifdef IN_PIN_COND_GLITCH_CNT_EN
  localparam bit GCNT = 1'b1;
`else
  localparam bit GCNT = 1'b0;
`endif

  logic            clk_i         = 1'b0;
  logic            rst_i         = 1'b0;
  logic [NP-1:0]   pins_i        = RST;
  logic [NP-1:0]   debounce_en_i = '1;
  logic            glitch_clr_i  = 1'b0;
  logic [NP-1:0]   pins_o, rise_o, fall_o;
  logic [NP*8-1:0] glitch_cnt_o;

  int total = 0;
  int bad   = 0;

  in_pin_conditioner #(
    .NumPins(NP), .SyncStages(SYNC), .DebounceCycles(DB), .ResetVal(RST)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pins_i        (pins_i),
    .debounce_en_i (debounce_en_i),
    .pins_o        (pins_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .glitch_clr_i  (glitch_clr_i),
    .glitch_cnt_o  (glitch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: pad samples delayed through a queue, then a mismatch run length per pin.
  logic [NP-1:0]   m_q[$];
  logic [NP-1:0]   m_pins, m_rise, m_fall;
  int              m_run [NP];
  int              m_gl  [NP];
  logic [NP*8-1:0] m_gvec;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < SYNC; i++) m_q.push_back(RST);
    m_pins = RST;
    m_rise = '0;
    m_fall = '0;
    m_gvec = '0;
    for (int n = 0; n < NP; n++) begin
      m_run[n] = 0;
      m_gl[n]  = 0;
    end
  endtask

  // Advance the model by the coming clock edge, then move to the next falling edge.
  task automatic tick();
    logic [NP-1:0] seen, nxt;
    if (!rst_i) begin
      seen = m_q.pop_front();
      m_q.push_back(pins_i);
      nxt = m_pins;
      for (int n = 0; n < NP; n++) begin
        if (!debounce_en_i[n]) begin
          nxt[n]   = seen[n];
          m_run[n] = 0;
        end else if (seen[n] != m_pins[n]) begin
          m_run[n] = m_run[n] + 1;
          if (m_run[n] == DB) begin
            nxt[n]   = seen[n];
            m_run[n] = 0;
          end
        end else begin
          if (m_run[n] > 0) m_gl[n] = (m_gl[n] < 255) ? m_gl[n] + 1 : 255;
          m_run[n] = 0;
        end
        if (glitch_clr_i) m_gl[n] = 0;
      end
      m_rise = nxt & ~m_pins;
      m_fall = ~nxt & m_pins;
      m_pins = nxt;
      for (int n = 0; n < NP; n++) m_gvec[8*n +: 8] = GCNT ? 8'(m_gl[n]) : 8'd0;
    end
    @(negedge clk_i);
  endtask

  task automatic glitch_pulse(input int p, input bit clr_evt);
    pins_i[p] = ~RST[p];
    repeat (3) tick();
    pins_i[p] = RST[p];
    repeat (2) tick();
    glitch_clr_i = clr_evt;
    tick();
    glitch_clr_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    model_reset();
    pins_i = RST;
    debounce_en_i = '1;
    glitch_clr_i = 1'b0;
    repeat (3) tick();
    total++;
    if (pins_o !== RST || rise_o !== '0 || fall_o !== '0) begin
      bad++;
      $display("FAIL reset_hold: pins=%b rise=%b fall=%b want %b/0/0", pins_o, rise_o, fall_o, RST);
    end
    total++;
    if (glitch_cnt_o !== '0) begin
      bad++;
      $display("FAIL reset_glitch: got %h want 0", glitch_cnt_o);
    end
    rst_i = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      total++;
      if ({pins_o, rise_o, fall_o} !== {RST, 10'b0}) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: pins=%b rise=%b fall=%b want %b/0/0", k, pins_o, rise_o, fall_o, RST);
      end
    end
  endtask

  task automatic test_debounce_rise();
    int lat = 0;
    pins_i[3] = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (pins_o[3] === 1'b1) lat = k;
    end
    total++;
    if (lat != SYNC + DB) begin bad++; $display("FAIL rise_latency: got %0d want %0d", lat, SYNC + DB); end
    total++;
    if (rise_o !== 5'b01000 || fall_o !== '0) begin
      bad++;
      $display("FAIL rise_pulse: rise=%b fall=%b want 01000/00000", rise_o, fall_o);
    end
    total++;
    if (pins_o !== 5'b01111) begin bad++; $display("FAIL rise_others: got %b want 01111", pins_o); end
    tick();
    total++;
    if (rise_o !== '0 || pins_o !== 5'b01111) begin
      bad++;
      $display("FAIL rise_one_cycle: rise=%b pins=%b want 00000/01111", rise_o, pins_o);
    end
  endtask

  task automatic test_glitch_reject();
    bit moved = 1'b0;
    pins_i[3] = 1'b0;
    repeat (30) tick();
    total++;
    if (pins_o !== RST) begin bad++; $display("FAIL glitch_pre: got %b want %b", pins_o, RST); end
    pins_i[3] = 1'b1;
    repeat (10) tick();
    pins_i[3] = 1'b0;
    repeat (30) begin
      tick();
      if (pins_o[3] !== 1'b0 || rise_o[3] !== 1'b0 || fall_o[3] !== 1'b0) moved = 1'b1;
    end
    total++;
    if (moved) begin bad++; $display("FAIL glitch_passed: pin3 moved, got 1 want 0"); end
    total++;
    if (glitch_cnt_o[31:24] !== (GCNT ? 8'd1 : 8'd0)) begin
      bad++;
      $display("FAIL glitch_count_p3: got %0d want %0d", glitch_cnt_o[31:24], GCNT ? 1 : 0);
    end
    total++;
    if (glitch_cnt_o !== m_gvec) begin bad++; $display("FAIL glitch_vec: got %h want %h", glitch_cnt_o, m_gvec); end
  endtask

  task automatic test_bypass();
    int lat = 0;
    debounce_en_i[0] = 1'b0;
    repeat (3) tick();
    total++;
    if (pins_o !== RST || fall_o !== '0) begin bad++; $display("FAIL bypass_idle: got %b want %b", pins_o, RST); end
    pins_i[0] = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (pins_o[0] === 1'b0) lat = k;
    end
    total++;
    if (lat != SYNC + 1) begin bad++; $display("FAIL bypass_latency: got %0d want %0d", lat, SYNC + 1); end
    total++;
    if (fall_o !== 5'b00001 || rise_o !== '0) begin
      bad++;
      $display("FAIL bypass_fall: fall=%b rise=%b want 00001/00000", fall_o, rise_o);
    end
    tick();
    total++;
    if (fall_o !== '0) begin bad++; $display("FAIL bypass_one_cycle: got %b want 00000", fall_o); end
  endtask

  task automatic test_reset_midcount();
    int lat = 0;
    pins_i[0] = 1'b1;
    repeat (5) tick();
    debounce_en_i[0] = 1'b1;
    total++;
    if (pins_o !== RST) begin bad++; $display("FAIL midrst_pre: got %b want %b", pins_o, RST); end
    pins_i[4] = 1'b1;
    repeat (SYNC + 9) tick();
    total++;
    if (pins_o !== RST) begin bad++; $display("FAIL midrst_early: got %b want %b", pins_o, RST); end
    rst_i = 1'b1;
    model_reset();
    #1;
    total++;
    if (pins_o !== RST || rise_o !== '0 || fall_o !== '0) begin
      bad++;
      $display("FAIL midrst_async: pins=%b rise=%b fall=%b want %b/0/0", pins_o, rise_o, fall_o, RST);
    end
    tick();
    rst_i = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (pins_o[4] === 1'b1) lat = k;
    end
    total++;
    if (lat != SYNC + DB) begin bad++; $display("FAIL midrst_latency: got %0d want %0d", lat, SYNC + DB); end
    total++;
    if (rise_o !== 5'b10000) begin bad++; $display("FAIL midrst_rise: got %b want 10000", rise_o); end
    pins_i[4] = 1'b0;
    repeat (30) tick();
  endtask

  task automatic test_simultaneous();
    int lat = 0;
    pins_i[3] = 1'b1;
    pins_i[2] = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (pins_o[3] === 1'b1 || pins_o[2] === 1'b0) lat = k;
    end
    total++;
    if (lat != SYNC + DB) begin bad++; $display("FAIL simul_latency: got %0d want %0d", lat, SYNC + DB); end
    total++;
    if (pins_o !== 5'b01011 || rise_o !== 5'b01000 || fall_o !== 5'b00100) begin
      bad++;
      $display("FAIL simul_edges: pins=%b rise=%b fall=%b want 01011/01000/00100", pins_o, rise_o, fall_o);
    end
    pins_i = RST;
    repeat (30) tick();
    total++;
    if (pins_o !== RST) begin bad++; $display("FAIL simul_restore: got %b want %b", pins_o, RST); end
  endtask

  task automatic test_glitch_saturate();
    for (int i = 0; i < 300; i++) glitch_pulse(1, 1'b0);
    total++;
    if (glitch_cnt_o[15:8] !== (GCNT ? 8'd255 : 8'd0)) begin
      bad++;
      $display("FAIL glitch_sat: got %0d want %0d", glitch_cnt_o[15:8], GCNT ? 255 : 0);
    end
    total++;
    if (glitch_cnt_o !== m_gvec) begin bad++; $display("FAIL glitch_sat_vec: got %h want %h", glitch_cnt_o, m_gvec); end
    glitch_pulse(1, 1'b1);
    total++;
    if (glitch_cnt_o !== '0) begin bad++; $display("FAIL glitch_clr_sat: got %h want 0", glitch_cnt_o); end
    glitch_pulse(1, 1'b0);
    total++;
    if (glitch_cnt_o[15:8] !== (GCNT ? 8'd1 : 8'd0)) begin
      bad++;
      $display("FAIL glitch_after_clr: got %0d want %0d", glitch_cnt_o[15:8], GCNT ? 1 : 0);
    end
    glitch_pulse(1, 1'b1);
    total++;
    if (glitch_cnt_o[15:8] !== 8'd0) begin
      bad++;
      $display("FAIL glitch_clr_wins: got %0d want 0", glitch_cnt_o[15:8]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) debounce_en_i = NP'($urandom) | NP'($urandom);
      for (int n = 0; n < NP; n++) begin
        if ($urandom_range(0, 11) == 0) pins_i[n] = ~pins_i[n];
      end
      glitch_clr_i = ($urandom_range(0, 99) == 0);
      tick();
      total++;
      if (pins_o !== m_pins) begin bad++; $display("FAIL rnd_pins cyc%0d: got %b want %b", c, pins_o, m_pins); end
      total++;
      if (rise_o !== m_rise) begin bad++; $display("FAIL rnd_rise cyc%0d: got %b want %b", c, rise_o, m_rise); end
      total++;
      if (fall_o !== m_fall) begin bad++; $display("FAIL rnd_fall cyc%0d: got %b want %b", c, fall_o, m_fall); end
      total++;
      if (glitch_cnt_o !== m_gvec) begin
        bad++;
        $display("FAIL rnd_glitch cyc%0d: got %h want %h", c, glitch_cnt_o, m_gvec);
      end
    end
    glitch_clr_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce_rise();
    test_glitch_reject();
    test_bypass();
    test_reset_midcount();
    test_simultaneous();
    test_glitch_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
